// File: rtl/mux4_rr_scheduler.sv
// mux4_rr_scheduler: round-robin 4-way grant scheduler with bounded hold and registered data sample
module mux4_rr_scheduler #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] in,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       out,
    output logic       valid
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_nx;
    logic [1:0] ptr, ptr_nx, sel_nx, pick;
    logic [3:0] hold_cnt, hold_nx;
    logic at_max, others, keep;
    always_comb begin
        pick = ptr;
        for (int i = 3; i >= 0; i--)
            if (req[ptr + 2'(i)]) pick = ptr + 2'(i);
    end
    assign at_max = hold_cnt >= 4'(MAX_HOLD);
    assign others = |(req & ~(4'b1 << sel));
    // the current owner keeps the grant until its budget runs out and someone else is waiting
    assign keep = req[sel] && (!at_max || !others);
    always_comb begin
        state_nx = state;
        sel_nx = sel;
        ptr_nx = ptr;
        hold_nx = hold_cnt;
        gnt = (state == GRANT) ? 4'b1 << sel : 4'b0;
        if (req == 4'b0) begin
            state_nx = IDLE;
        end else if (state == GRANT && keep) begin
            hold_nx = at_max ? hold_cnt : hold_cnt + 4'd1;
        end else begin
            state_nx = GRANT;
            sel_nx = pick;
            ptr_nx = pick + 2'd1;
            hold_nx = 4'd1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel <= 2'd0;
            ptr <= 2'd0;
            hold_cnt <= 4'd0;
            out <= 1'b0;
            valid <= 1'b0;
        end else begin
            state <= state_nx;
            sel <= sel_nx;
            ptr <= ptr_nx;
            hold_cnt <= hold_nx;
            valid <= state == GRANT && req[sel];
            if (state == GRANT && req[sel]) out <= in[sel];
        end
    end
endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// tb_mux4_rr_scheduler: directed self-checking bench for mux4_rr_scheduler
module tb_mux4_rr_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] req = 4'b0;
    logic [3:0] in = 4'b0;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic out, valid;
    int total = 0;
    int bad = 0;

    mux4_rr_scheduler #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .in(in),
        .gnt(gnt), .sel(sel), .out(out), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req = 4'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    initial begin
        int es, ps;
        #1;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_sel", sel, 2'd0);
        chk("rst_out", out, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_hold", dut.hold_cnt, 4'd0);

        // single requester, then idle, then check pointer retained across idle
        do_reset;
        req = 4'b0100;
        in = 4'b0100;
        tick;
        chk("single_gnt", gnt, 4'b0100);
        chk("single_sel", sel, 2'd2);
        chk("single_valid0", valid, 1'b0);
        tick;
        chk("single_valid", valid, 1'b1);
        chk("single_out", out, 1'b1);
        req = 4'b0000;
        tick;
        chk("idle_gnt", gnt, 4'b0000);
        chk("idle_sel_held", sel, 2'd2);
        chk("idle_valid", valid, 1'b0);
        chk("idle_out_held", out, 1'b1);
        tick;
        chk("idle2_gnt", gnt, 4'b0000);
        req = 4'b1100;
        tick;
        chk("ptr_kept_sel", sel, 2'd3);
        chk("ptr_kept_gnt", gnt, 4'b1000);

        // all requesting: 4 cycles each, order 0,1,2,3,0, data lags sel by one
        do_reset;
        req = 4'b1111;
        in = 4'b0101;
        ps = 0;
        for (int k = 0; k <= 20; k++) begin
            tick;
            es = (k / 4) % 4;
            chk($sformatf("rr_sel_%0d", k), sel, es);
            chk($sformatf("rr_gnt_%0d", k), gnt, 4'b1 << es);
            if (k > 0) begin
                chk($sformatf("rr_valid_%0d", k), valid, 1'b1);
                chk($sformatf("rr_out_%0d", k), out, (ps % 2 == 0) ? 1 : 0);
            end
            ps = es;
        end

        // asynchronous reset mid-grant
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_gnt", gnt, 4'b0000);
        chk("async_valid", valid, 1'b0);
        chk("async_sel", sel, 2'd0);
        tick;
        tick;
        tick;
        chk("inrst_gnt", gnt, 4'b0000);
        rst_n = 1'b1;
        tick;
        chk("postrst_sel", sel, 2'd0);
        chk("postrst_gnt", gnt, 4'b0001);

        // early release: requester 0 drops after 2 cycles
        do_reset;
        req = 4'b0011;
        tick;
        chk("early_sel_a", sel, 2'd0);
        tick;
        chk("early_sel_b", sel, 2'd0);
        req = 4'b0010;
        tick;
        chk("early_sel_c", sel, 2'd1);
        chk("early_gnt_c", gnt, 4'b0010);

        // lone hog saturates hold count and keeps the grant
        do_reset;
        req = 4'b1000;
        in = 4'b1000;
        for (int k = 0; k < 20; k++) begin
            tick;
            chk($sformatf("hog_gnt_%0d", k), gnt, 4'b1000);
            if (k > 0) chk($sformatf("hog_valid_%0d", k), valid, 1'b1);
        end
        chk("hog_hold", dut.hold_cnt, 4'd4);
        chk("hog_out", out, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux4_rr_scheduler.md
MUX4_RR_SCHEDULER -- requirements
Module: mux4_rr_scheduler

Interface
REQ-001 SHALL provide parameter MAX_HOLD, default 4, meaning the maximum consecutive grant cycles per requester while others wait (legal range 1..15).
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL provide port req, input, 4, per-requester request lines; bit i is requester i.
REQ-005 SHALL provide port in, input, 4, per-requester data bits; bit i is requester i's data.
REQ-006 SHALL provide port gnt, output, 4, one-hot grant, or all-zero when idle.
REQ-007 SHALL provide port sel, output, 2, binary index of the granted requester, for the downstream 4:1 mux select.
REQ-008 SHALL provide port out, output, 1, registered copy of in[sel] sampled while granted.
REQ-009 SHALL provide port valid, output, 1, high when out carries a granted sample.

Function
REQ-010 SHALL implement two states: IDLE (gnt=0) and GRANT (gnt one-hot, gnt[sel]=1).
REQ-011 SHALL keep a 2-bit rotating priority pointer ptr; the search order is ptr, ptr+1, ptr+2, ptr+3, mod 4.
REQ-012 SHALL, in IDLE with req!=0 at an edge, enter GRANT at that edge.
- sel = first requesting index in search order.
- hold_cnt = 1.
- ptr = sel+1 mod 4.
REQ-013 SHALL, in IDLE with req=0, remain in IDLE with sel and ptr unchanged.
REQ-014 SHALL, in GRANT with req[sel]=1 and hold_cnt<MAX_HOLD, keep sel and increment hold_cnt.
REQ-015 SHALL, in GRANT with req[sel]=1, hold_cnt=MAX_HOLD and another req bit set, rotate to the next requester per REQ-012 with no idle cycle.
REQ-016 SHALL, in GRANT with req[sel]=1, hold_cnt=MAX_HOLD and no other req, keep the grant with hold_cnt saturated at MAX_HOLD.
REQ-017 SHALL, in GRANT with req[sel]=0 and other req pending, switch to the next requester per REQ-012 at the same edge with no idle cycle.
REQ-018 SHALL, in GRANT with req=0, return to IDLE; gnt=0 from that edge and sel holds its last value.
REQ-019 SHALL sample at each edge: out <= in[sel] and valid <= 1 if the state before the edge was GRANT and req[sel]=1; otherwise valid <= 0 and out holds its value.
REQ-020 SHALL guarantee gnt is never multi-hot and gnt changes only at clock edges.
REQ-021 SHALL ignore req changes between edges; only edge-sampled values matter.
REQ-022 SHALL bound the worst-case wait of a continuously requesting input to 3*MAX_HOLD cycles.
REQ-023 SHALL implement hold_cnt as 4 bits, never wrapping.

Reset
REQ-024 SHALL, while rst_n=0, force regardless of clk:
- state=IDLE, gnt=0000, sel=00, out=0, valid=0, ptr=00, hold_cnt=0.
REQ-025 SHALL, on reset mid-grant, drop gnt and valid immediately (asynchronously).
REQ-026 SHALL, after rst_n rises, arbitrate from ptr=00 at the first edge.

Verification
REQ-027 Single requester: req=0100, in=0100, from reset -> edge1 gnt=0100, sel=10; edge2 valid=1, out=1.
REQ-028 All requesting, MAX_HOLD=4: req=1111 held -> grant order 0,1,2,3,0, each held exactly 4 cycles; gnt transitions without gaps.
REQ-029 Early release: req=0011, then requester 0 drops req after 2 cycles -> sel=01 at the very next edge, with no IDLE cycle.
REQ-030 Lone hog: req=1000 held 20 cycles -> gnt=1000 throughout, hold_cnt=4 saturated, valid=1 continuously.
REQ-031 Reset mid-grant: req=1111, rst_n low for 3 cycles mid-burst -> gnt=0000 and valid=0 immediately; after release the first grant is requester 0.
REQ-032 Data path check: req=1111, in=0101 -> out sequence follows the sel sequence with a one-cycle lag (1 for sel 0 and 2; 0 for sel 1 and 3).
